// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller driving a dual-port RAM with a 2-entry output skid.
// RAM port a takes writes; port b reads with one cycle of latency into the skid registers.
module dpram_fifo_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MEM_LENGTH = 64,
    localparam int AW         = $clog2(MEM_LENGTH),
    localparam int CW         = AW + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  ram_wen,
    output logic [AW-1:0]         ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [AW-1:0]         ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [AW:0] MEM_FULL = (AW + 1)'(MEM_LENGTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] sk0_q, sk0_d;
    logic [DATA_WIDTH-1:0] sk1_q, sk1_d;
    logic [1:0]            sk_cnt_q, sk_cnt_d;

    logic [AW:0] mem_cnt;
    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  occ_after_pop;
    logic [1:0]  sk_n;

    always_comb begin
        mem_cnt       = wr_ptr_q - rd_ptr_q;
        in_ready      = !rst && (mem_cnt != MEM_FULL);
        push          = in_valid && in_ready;
        out_valid     = (sk_cnt_q != 2'd0);
        pop           = out_valid && out_ready;
        // Skid occupancy left after this cycle's pop, counting the read already in flight.
        occ_after_pop = {1'b0, sk_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        issue         = (mem_cnt != '0) && (occ_after_pop < 3'd2);
    end

    always_comb begin
        ram_wen   = push;
        ram_waddr = wr_ptr_q[AW-1:0];
        ram_wdata = in_data;
        ram_raddr = rd_ptr_q[AW-1:0];
        out_data  = sk0_q;
        count     = CW'(mem_cnt) + CW'(rd_pend_q) + CW'(sk_cnt_q);
        empty     = (count == '0);
        full      = (mem_cnt == MEM_FULL);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + ((AW + 1)'(push));
        rd_ptr_d  = rd_ptr_q + ((AW + 1)'(issue));
        rd_pend_d = issue;
    end

    // Pop shifts first, then the returning RAM word lands at the new tail.
    always_comb begin
        sk0_d = sk0_q;
        sk1_d = sk1_q;
        sk_n  = sk_cnt_q;
        if (pop) begin
            sk0_d = sk1_q;
            sk_n  = sk_n - 2'd1;
        end
        if (rd_pend_q) begin
            if (sk_n == 2'd0) begin
                sk0_d = ram_rdata;
            end else begin
                sk1_d = ram_rdata;
            end
            sk_n = sk_n + 2'd1;
        end
        sk_cnt_d = sk_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            sk0_q     <= '0;
            sk1_q     <= '0;
            sk_cnt_q  <= 2'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_pend_q <= rd_pend_d;
            sk0_q     <= sk0_d;
            sk1_q     <= sk1_d;
            sk_cnt_q  <= sk_cnt_d;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - scoreboard bench for dpram_fifo_ctrl with a behavioural RAM.
module tb_dpram_fifo_ctrl;

    localparam int DW = 8;
    localparam int ML = 64;
    localparam int AW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:ML-1];
    logic [DW-1:0] q [$];
    int            n_checks = 0;
    int            n_pass = 0;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .MEM_LENGTH(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        logic [DW-1:0] e;
        @(negedge clk);
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("ready_vs_full", 32'(in_ready), 32'(!full));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("pop_underflow", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("data", 32'(out_data), 32'(e));
            end
        end
        if (in_valid && in_ready) q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && q.size() != 0; k++) cycle();
        chk("drain_done", 32'(q.size()), 32'd0);
        cycle();
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        int acc;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        repeat (2) cycle();

        // Single word latency
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("lat_t1", 32'(out_valid), 32'd0);
        cycle();
        chk("lat_t2", 32'(out_valid), 32'd0);
        cycle();
        chk("lat_t3_valid", 32'(out_valid), 32'd1);
        chk("lat_t3_data", 32'(out_data), 32'h11);
        cycle();
        chk("lat_count0", 32'(count), 32'd0);

        // Full-rate stream
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = DW'(i);
            if (i >= 3) chk("stream_nogap", 32'(out_valid), 32'd1);
            cycle();
        end
        drain();

        // Fill to capacity with the consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int k = 0; k < 100; k++) begin
            if (!in_ready) break;
            in_data = DW'(8'h80 + k);
            acc++;
            cycle();
        end
        chk("fill_accepted", 32'(acc), 32'd66);
        chk("fill_count", 32'(count), 32'd66);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        repeat (3) cycle();
        chk("fill_hold_count", 32'(count), 32'd66);
        drain();

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            cycle();
        end
        drain();

        // Reset with 40 words held and a read in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 41; k++) begin
            in_data = DW'(8'h40 + k);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("pre_rst_count", 32'(count), 32'd40);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) cycle();
        chk("post_rst_first_valid", 32'(out_valid), 32'd1);
        chk("post_rst_first_data", 32'(out_data), 32'hA5);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
